axi_burst_mem: RTL and testbench
================================

# axi_burst_mem

Burst memory responder for the simplified AXI-style DUT interface: the target end of the interface the testbench initiator drives. It accepts one write or read burst command per `transfer` pulse and supports FIXED/INCR/WRAP bursts of 4-byte beats. It stores write data into an internal word memory, returns read data with valid/ready backpressure, and reports a per-burst response code. It sits as the DUT behind `interf_dut`, and it is what the interface assertions observe.

## Interface
- `DATA_W`, 32, data beat width in bits; fixed at 4-byte beats.
- `ADDR_W`, 9, byte address width.
- `MEM_WORDS`, 128, memory depth in `DATA_W` words; byte space is 0 to 4*MEM_WORDS-1.
- `aclk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `transfer`  in  1  command strobe; sampled only in IDLE.
- `wr_rd`  in  1  1 = write burst, 0 = read burst.
- `btyp`  in  2  0 = FIXED, 1 = INCR, 2 = WRAP, 3 = reserved.
- `blen`  in  5  beat count, 1 to 16.
- `bsize`  in  3  bytes per beat; only 4 is legal.
- `wadd`  in  ADDR_W  write start byte address.
- `radd`  in  ADDR_W  read start byte address.
- `datain`  in  DATA_W  write beat data.
- `din_valid`  in  1  write beat valid.
- `din_ready`  out  1  write beat accepted when `din_valid && din_ready`.
- `dataout`  out  DATA_W  read beat data (registered).
- `dout_valid`  out  1  read beat valid.
- `dout_ready`  in  1  read beat consumed when `dout_valid && dout_ready`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse at burst end.
- `resp`  out  2  0 = OKAY, 2 = SLVERR; valid while `done` is high.

## Operation
- FSM states: IDLE, WDATA, RDATA, RESP.
- **Command acceptance.** In IDLE with `transfer`=1, all command fields are latched.
  - Start address is `wadd` if `wr_rd`=1, else `radd`.
  - Beat counter is loaded with `blen`.
  - `transfer` is ignored in every other state.
- **Error check at acceptance.** The command is an error if any of the following holds:
  - `bsize`≠4, or `btyp`=3, or `blen`=0;
  - start address not 4-aligned;
  - INCR with start+4*(blen-1) ≥ 4*MEM_WORDS;
  - WRAP with `blen` not in {2,4,8,16};
  - start ≥ 4*MEM_WORDS.
  
  An error command goes to RESP with SLVERR. No beats are exchanged and memory is untouched.
- **Beat address sequencing.** Word index = addr>>2.
  - FIXED: address is held constant.
  - INCR: addr += 4 per beat.
  - WRAP: addr = base + ((addr+4−base) mod (4*blen)), where base = start & ~(4*blen−1).
- **WDATA.** `din_ready`=1. Each accepted beat writes `datain` to mem[addr], advances the address and decrements the counter. The last beat goes to RESP with OKAY.
- **RDATA.** `dataout` holds the current beat and `dout_valid`=1. On a handshake, the next beat loads. On the last beat's handshake, `dout_valid` drops and the FSM goes to RESP with OKAY.
- **RESP.** `done`=1 for one cycle with `resp`, then IDLE.
- Memory contents are not reset. Reads of never-written words return X in simulation.

## Timing
- **Reset values.** On `resetn` low: state IDLE; `din_ready`, `dout_valid`, `busy`, `done` = 0; `dataout` = 0; `resp` = 0.
- **Reset mid-burst.** An assertion mid-burst aborts immediately: no `done`, and partially written words are kept.
- **Command cycle.** `transfer` is sampled at edge T. From T+1: `busy`=1, and either `din_ready`=1 (write) or `dout_valid`=1 with beat 0 on `dataout` (read).
- **Throughput.** One beat per cycle with no stall.
- **Write completion.** The last write beat is accepted at edge E; `done` is high in cycle E+1; `busy` drops at E+2.
- **Read completion.** The last read handshake is at edge E; `done` is high in cycle E+1.
- **Error path.** For an error command, `done` is high in cycle T+1.
- **Read backpressure.** With `dout_ready`=0, `dataout` and `dout_valid` hold stable.
- **Write stall.** `din_valid`=0 stalls the write; `din_ready` stays 1.
- **Back-to-back commands.** `transfer` high in the `done` cycle is ignored. The next command is accepted no earlier than the cycle after `done`.

## Configuration
- `AXI_MEM_ERR_CNT_EN` defined:
  - Adds output `err_count [7:0]`, reset value 0.
  - Increments once per `done` with SLVERR.
  - Saturates at 255.
- `AXI_MEM_ERR_CNT_EN` undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- **INCR write/read.** Write INCR, `wadd`=0x010, `blen`=4, data 100,200,300,400. Then read INCR, `radd`=0x010, `blen`=4 -> `dataout` 100,200,300,400 on consecutive cycles; `resp`=0 on both `done` pulses.
- **WRAP read.** Write INCR at 0x010 with 500,600,700,800. Then read WRAP, `radd`=0x01C, `blen`=4 -> 800,500,600,700 (addresses 0x1C,0x10,0x14,0x18).
- **FIXED write.** Write FIXED, `wadd`=0x020, `blen`=4, data 5,6,7,8. Then read INCR 0x020 `blen`=1 -> 8.
- **Error commands.** Each command `done` one cycle after acceptance with `resp`=2, and `din_ready` never asserts; with the macro, `err_count`=3.
  - `bsize`=2
  - `wadd`=0x006
  - `btyp`=2 with `blen`=12
- **Read backpressure.** Read INCR `blen`=8 with `dout_ready` low for 3 cycles at beat 2 -> `dataout` and `dout_valid` hold; all 8 beats delivered in order.
- **Reset mid-write.** Assert `resetn` low after beat 2 of a 4-beat write at 0x040 -> outputs go to reset values immediately; no `done`. After release, a read of 0x040 `blen`=2 returns the two written values.

Source files
------------

// File: rtl/axi_burst_mem.sv
// axi_burst_mem: burst memory responder for FIXED/INCR/WRAP bursts of 4-byte beats.
// One command per transfer pulse, valid/ready beat handshakes, per-burst OKAY/SLVERR.
// Optional: define AXI_MEM_ERR_CNT_EN to add a saturating SLVERR counter (err_count).
module axi_burst_mem #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int MEM_WORDS = 128
) (
    input  logic              aclk,
    input  logic              resetn,
    input  logic              transfer,
    input  logic              wr_rd,
    input  logic [1:0]        btyp,
    input  logic [4:0]        blen,
    input  logic [2:0]        bsize,
    input  logic [ADDR_W-1:0] wadd,
    input  logic [ADDR_W-1:0] radd,
    input  logic [DATA_W-1:0] datain,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] dataout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
`ifdef AXI_MEM_ERR_CNT_EN
    output logic [7:0]        err_count,
`endif
    output logic [1:0]        resp
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    // Extra headroom so burst-end arithmetic cannot wrap.
    localparam int EW    = ADDR_W + 2;

    localparam logic [1:0] B_FIXED = 2'd0;
    localparam logic [1:0] B_INCR  = 2'd1;
    localparam logic [1:0] B_WRAP  = 2'd2;
    localparam logic [1:0] R_OKAY  = 2'd0;
    localparam logic [1:0] R_SLV   = 2'd2;

    typedef enum logic [1:0] {IDLE, WDATA, RDATA, RESP} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mem [MEM_WORDS];
    logic [ADDR_W-1:0]   addr, addr_nxt, wrap_mask;
    logic [1:0]          btyp_q;
    logic [4:0]          cnt;
    logic [1:0]          resp_q;

    logic [ADDR_W-1:0]   start_addr;
    logic [EW-1:0]       span_end;
    logic                wrap_len_ok, cmd_err, last, wr_fire, rd_fire, accept;

    assign start_addr  = wr_rd ? wadd : radd;
    assign span_end    = EW'(start_addr) + (EW'(blen) << 2) - EW'(4);
    assign wrap_len_ok = (blen == 5'd2) || (blen == 5'd4) || (blen == 5'd8) || (blen == 5'd16);
    assign cmd_err     = (bsize != 3'd4) || (btyp == 2'd3) || (blen == 5'd0)
                      || (start_addr[1:0] != 2'b00)
                      || ((btyp == B_INCR) && (span_end >= EW'(4 * MEM_WORDS)))
                      || ((btyp == B_WRAP) && !wrap_len_ok)
                      || (EW'(start_addr) >= EW'(4 * MEM_WORDS));

    assign accept  = (state == IDLE) && transfer;
    assign last    = (cnt == 5'd1);
    assign wr_fire = (state == WDATA) && din_valid;
    assign rd_fire = (state == RDATA) && dout_ready;

    assign busy       = (state != IDLE);
    assign din_ready  = (state == WDATA);
    assign dout_valid = (state == RDATA);
    assign done       = (state == RESP);
    assign resp       = resp_q;

    // Next beat address; WRAP keeps the high bits and wraps the low bits inside the window.
    always_comb begin
        addr_nxt = addr;
        case (btyp_q)
            B_FIXED: addr_nxt = addr;
            B_INCR:  addr_nxt = addr + ADDR_W'(4);
            B_WRAP:  addr_nxt = (addr & ~wrap_mask) | ((addr + ADDR_W'(4)) & wrap_mask);
            default: addr_nxt = addr;
        endcase
    end

    // State register.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (transfer) state_nxt = cmd_err ? RESP : (wr_rd ? WDATA : RDATA);
            WDATA:   if (din_valid && last) state_nxt = RESP;
            RDATA:   if (dout_ready && last) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, beat sequencing and registered read data.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            addr      <= '0;
            wrap_mask <= '0;
            btyp_q    <= B_FIXED;
            cnt       <= '0;
            resp_q    <= R_OKAY;
            dataout   <= '0;
        end else if (accept) begin
            addr      <= start_addr;
            wrap_mask <= ADDR_W'({blen, 2'b00}) - ADDR_W'(1);
            btyp_q    <= btyp;
            cnt       <= blen;
            resp_q    <= cmd_err ? R_SLV : R_OKAY;
            if (!wr_rd && !cmd_err) dataout <= mem[start_addr[IDX_W+1:2]];
        end else if (wr_fire || rd_fire) begin
            addr <= addr_nxt;
            cnt  <= cnt - 5'd1;
            if (rd_fire && !last) dataout <= mem[addr_nxt[IDX_W+1:2]];
        end
    end

    // Word memory; contents survive reset.
    always_ff @(posedge aclk) begin
        if (wr_fire) mem[addr[IDX_W+1:2]] <= datain;
    end

`ifdef AXI_MEM_ERR_CNT_EN
    // Count SLVERR completions, saturating at 255.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) err_count <= '0;
        else if ((state == RESP) && (resp_q == R_SLV) && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_axi_burst_mem.sv
// Directed bench for axi_burst_mem; read data checked against a queue scoreboard.
module tb_axi_burst_mem;

    logic        aclk = 1'b0;
    logic        resetn;
    logic        transfer, wr_rd, din_valid, dout_ready;
    logic [1:0]  btyp;
    logic [4:0]  blen;
    logic [2:0]  bsize;
    logic [8:0]  wadd, radd;
    logic [31:0] datain;
    logic        din_ready, dout_valid, busy, done;
    logic [31:0] dataout;
    logic [1:0]  resp;
`ifdef AXI_MEM_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] beat_data [16];

    axi_burst_mem dut (
        .aclk(aclk), .resetn(resetn), .transfer(transfer), .wr_rd(wr_rd),
        .btyp(btyp), .blen(blen), .bsize(bsize), .wadd(wadd), .radd(radd),
        .datain(datain), .din_valid(din_valid), .din_ready(din_ready),
        .dataout(dataout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done),
`ifdef AXI_MEM_ERR_CNT_EN
        .err_count(err_count),
`endif
        .resp(resp)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic fill(input logic [31:0] base, input logic [31:0] inc);
        for (int i = 0; i < 16; i++) beat_data[i] = base + inc * 32'(i);
    endtask

    // Issue a write command and stream n beats from beat_data without stalls.
    task automatic do_write(input logic [8:0] a, input logic [1:0] t, input logic [4:0] n);
        wr_rd = 1'b1; wadd = a; radd = '0; btyp = t; blen = n; bsize = 3'd4; transfer = 1'b1;
        step();
        transfer = 1'b0;
        chk("wr_busy", busy, 1);
        chk("wr_din_ready", din_ready, 1);
        for (int i = 0; i < int'(n); i++) begin
            datain = beat_data[i]; din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        chk("wr_done", done, 1);
        chk("wr_resp", resp, 0);
        step();
        chk("wr_idle", busy, 0);
    endtask

    // Issue an error command; done must follow one cycle later with SLVERR.
    // A transfer in the done cycle must be ignored.
    task automatic do_err(input string tag, input logic [8:0] a, input logic [1:0] t,
                          input logic [4:0] n, input logic [2:0] sz);
        wr_rd = 1'b1; wadd = a; radd = '0; btyp = t; blen = n; bsize = sz; transfer = 1'b1;
        step();
        transfer = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_resp"}, resp, 2);
        chk({tag, "_din_ready"}, din_ready, 0);
        wr_rd = 1'b0; radd = 9'h010; btyp = 2'd1; blen = 5'd1; bsize = 3'd4; transfer = 1'b1;
        step();
        transfer = 1'b0;
        chk({tag, "_ignored_busy"}, busy, 0);
        chk({tag, "_ignored_valid"}, dout_valid, 0);
    endtask

    // Read burst; expected beats must already be on exp_q. Optional stall before beat sb.
    task automatic do_read(input logic [8:0] a, input logic [1:0] t, input logic [4:0] n,
                           input int sb, input int slen);
        int beats, stall, cyc;
        wr_rd = 1'b0; radd = a; wadd = '0; btyp = t; blen = n; bsize = 3'd4;
        dout_ready = 1'b0; transfer = 1'b1;
        step();
        transfer = 1'b0;
        chk("rd_busy", busy, 1);
        beats = 0; stall = slen; cyc = 0;
        while (beats < int'(n) && cyc < 200) begin
            chk("rd_valid", dout_valid, 1);
            if (exp_q.size() == 0) begin
                chk("rd_scoreboard_empty", 32'(exp_q.size()), 1);
                break;
            end
            if (beats == sb && stall > 0) begin
                dout_ready = 1'b0;
                chk("rd_hold", dataout, exp_q[0]);
                stall--;
            end else begin
                dout_ready = 1'b1;
                chk("rd_data", dataout, exp_q.pop_front());
                beats++;
            end
            step();
            cyc++;
        end
        dout_ready = 1'b0;
        if (beats < int'(n)) chk("rd_timeout", 32'(beats), 32'(n));
        chk("rd_done", done, 1);
        chk("rd_resp", resp, 0);
        chk("rd_valid_drop", dout_valid, 0);
        step();
        chk("rd_idle", busy, 0);
    endtask

    initial begin
        resetn = 1'b0; transfer = 1'b0; wr_rd = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        btyp = '0; blen = '0; bsize = '0; wadd = '0; radd = '0; datain = '0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_dataout", dataout, 0);
        chk("rst_resp", resp, 0);
`ifdef AXI_MEM_ERR_CNT_EN
        chk("rst_err_count", err_count, 0);
`endif
        resetn = 1'b1;
        step();

        // INCR write then INCR read
        fill(100, 100);
        do_write(9'h010, 2'd1, 5'd4);
        exp_q.push_back(100); exp_q.push_back(200); exp_q.push_back(300); exp_q.push_back(400);
        do_read(9'h010, 2'd1, 5'd4, -1, 0);

        // WRAP read starting mid-window
        fill(500, 100);
        do_write(9'h010, 2'd1, 5'd4);
        exp_q.push_back(800); exp_q.push_back(500); exp_q.push_back(600); exp_q.push_back(700);
        do_read(9'h01C, 2'd2, 5'd4, -1, 0);

        // FIXED write lands every beat on one word
        fill(5, 1);
        do_write(9'h020, 2'd0, 5'd4);
        exp_q.push_back(8);
        do_read(9'h020, 2'd1, 5'd1, -1, 0);

        // Error commands
        do_err("err_bsize", 9'h010, 2'd1, 5'd4, 3'd2);
        do_err("err_align", 9'h006, 2'd1, 5'd4, 3'd4);
        do_err("err_wraplen", 9'h010, 2'd2, 5'd12, 3'd4);
`ifdef AXI_MEM_ERR_CNT_EN
        chk("err_count", err_count, 3);
`endif

        // Read backpressure: 3-cycle stall at beat 2
        fill(1000, 1);
        do_write(9'h080, 2'd1, 5'd8);
        for (int i = 0; i < 8; i++) exp_q.push_back(1000 + 32'(i));
        do_read(9'h080, 2'd1, 5'd8, 2, 3);

        // Reset mid-write after two beats
        fill(11, 11);
        wr_rd = 1'b1; wadd = 9'h040; btyp = 2'd1; blen = 5'd4; bsize = 3'd4; transfer = 1'b1;
        step();
        transfer = 1'b0;
        for (int i = 0; i < 2; i++) begin
            datain = beat_data[i]; din_valid = 1'b1;
            step();
        end
        resetn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_din_ready", din_ready, 0);
        chk("midrst_done", done, 0);
        chk("midrst_dataout", dataout, 0);
        din_valid = 1'b0;
        step();
        chk("midrst_no_done", done, 0);
        resetn = 1'b1;
        step();
        chk("midrst_no_done_after", done, 0);
        exp_q.push_back(11); exp_q.push_back(22);
        do_read(9'h040, 2'd1, 5'd2, -1, 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
